rx_bit_timer: RTL and testbench
===============================

Name: rx_bit_timer

Overview:
- Bit-timing stage of the USB 1.1 receive path.
- Sits between edge detection and the receive shift register.
- Keeps a sample-phase counter that re-aligns on every data edge and issues a one-cycle shift_enable at the mid-bit sample point.
- Counts received bits, skips stuffed bits, and pulses byte_received after each full byte.

Parameters:
- SAMPLES_PER_BIT, 8, clock cycles per USB bit time; legal range 4..15.
- SAMPLE_POINT, 4, phase value at which the bit is sampled; legal range 2..SAMPLES_PER_BIT-1.
- BITS_PER_BYTE, 8, counted (non-stuff) bits per byte; legal range 2..15.

Ports:
- clk  in  1  system clock, SAMPLES_PER_BIT times the bit rate.
- n_rst  in  1  reset; asynchronous assert, active-low.
- enable_timer  in  1  high while a packet is being received; low holds the block idle.
- d_edge  in  1  one-cycle pulse on any transition of the synchronized line; re-aligns the phase.
- stuff_bit  in  1  qualifies the current sample as a stuffed bit; sampled only when shift_enable is decoded.
- shift_enable  out  1  one-cycle strobe to shift in the current data bit.
- byte_received  out  1  one-cycle pulse, cycle after the final shift of a byte.
- bit_count  out  $clog2(BITS_PER_BYTE)  counted bits of the current byte, 0..BITS_PER_BYTE-1.
- sample_phase  out  $clog2(SAMPLES_PER_BIT+1)  current phase; 0 = idle, otherwise 1..SAMPLES_PER_BIT.

Behaviour:
- Clock and reset: single clock clk; reset n_rst is asynchronous and active-low.
- Reset values: sample_phase=0, bit_count=0, byte_received=0, shift_enable=0.
- State: phase register P, bit counter B, registered byte_received flag.
- shift_enable is decoded from registered state only: (P==SAMPLE_POINT) && !stuff_bit && enable_timer. No other input-to-output combinational path.

Next-state priority, highest first:
1. enable_timer==0: P<=0, B<=0, byte_received<=0. This overrides d_edge and stuff_bit.
2. d_edge==1: P<=1. This applies from any phase, including P==0.
3. P==0: P<=1 (start of reception).
4. P==SAMPLES_PER_BIT: P<=1 (wrap).
5. Otherwise: P<=P+1.

Bit counting:
- On a cycle with shift_enable==1:
  - If B==BITS_PER_BYTE-1: B<=0 and byte_received<=1.
  - Otherwise: B<=B+1 and byte_received<=0.
- On every other enabled cycle: byte_received<=0 and B holds.
- A sample with stuff_bit==1 produces no shift_enable and no B change.

Timing:
- enable_timer rises and is first sampled at edge k: P=1 from edge k.
- First shift_enable is high in the cycle with P==SAMPLE_POINT, i.e. SAMPLE_POINT-1 cycles after edge k.
- With no edges, shift_enable repeats every SAMPLES_PER_BIT cycles.
- byte_received is high exactly one cycle, immediately after the BITS_PER_BYTE-th counted shift_enable.

Boundary conditions:
- d_edge in the same cycle as P==SAMPLE_POINT: shift_enable is still asserted that cycle, and P goes to 1.
- d_edge while P==SAMPLES_PER_BIT: P goes to 1 (same result as the wrap).
- Back-to-back d_edge pulses: P stays at 1, and no shift_enable is issued until SAMPLE_POINT-1 edge-free cycles have elapsed.
- enable_timer drop mid-byte: the partial byte is discarded, B=0, and no byte_received pulse is issued.
- enable_timer drop in the cycle byte_received would be set: byte_received stays 0.
- Asynchronous reset mid-operation: all state returns immediately to the reset values.
- Arithmetic: P and B are unsigned. P never exceeds SAMPLES_PER_BIT and B never exceeds BITS_PER_BYTE-1; wrap logic uses explicit compares, not overflow.

Test Plan:
1. Reset and idle: n_rst low with enable_timer=1 -> all outputs 0. Release with enable_timer=0 for 20 cycles -> sample_phase=0 and no strobes.
2. Free-running byte (defaults, no d_edge): raise enable_timer before edge 0 -> shift_enable high at cycles 3, 11, 19, ..., 59; bit_count steps 1..7 then 0; byte_received high at cycle 60 only.
3. Re-alignment: d_edge pulsed in the cycle with sample_phase=6 -> next phase is 1, and the next shift_enable comes 3 cycles later rather than 5.
4. Stuff bit: stuff_bit=1 at the 3rd sample point -> no shift_enable that cycle and bit_count holds at 2. byte_received is delayed by 8 cycles (cycle 68).
5. Abort: drop enable_timer when bit_count=5 -> next cycle sample_phase=0 and bit_count=0. No byte_received. Re-enabling restarts timing exactly as in scenario 2.
6. Simultaneous events: d_edge at the sample point -> shift_enable still issued and next phase is 1. Assert n_rst mid-byte -> outputs clear asynchronously before the next clk edge.

Source files
------------

// File: rtl/rx_bit_timer.sv
// USB 1.1 receive bit timer: edge-aligned sample-phase counter, mid-bit shift strobe,
// stuffed-bit skipping and per-byte completion pulse.
module rx_bit_timer #(
    parameter int unsigned SAMPLES_PER_BIT = 8,
    parameter int unsigned SAMPLE_POINT    = 4,
    parameter int unsigned BITS_PER_BYTE   = 8
) (
    input  logic                                     clk,
    input  logic                                     n_rst,
    input  logic                                     enable_timer,
    input  logic                                     d_edge,
    input  logic                                     stuff_bit,
    output logic                                     shift_enable,
    output logic                                     byte_received,
    output logic [$clog2(BITS_PER_BYTE)-1:0]         bit_count,
    output logic [$clog2(SAMPLES_PER_BIT+1)-1:0]     sample_phase
);

    localparam int unsigned PW = $clog2(SAMPLES_PER_BIT + 1);
    localparam int unsigned BW = $clog2(BITS_PER_BYTE);

    localparam logic [PW-1:0] PHASE_ONE  = PW'(1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(SAMPLES_PER_BIT);
    localparam logic [PW-1:0] PHASE_SMP  = PW'(SAMPLE_POINT);
    localparam logic [BW-1:0] BIT_LAST   = BW'(BITS_PER_BYTE - 1);

    logic [PW-1:0] phase_q, phase_d;
    logic [BW-1:0] bit_q, bit_d;
    logic          byte_q, byte_d;

    always_comb begin
        shift_enable = enable_timer && !stuff_bit && (phase_q == PHASE_SMP);
    end

    always_comb begin
        phase_d = phase_q;
        bit_d   = bit_q;
        byte_d  = 1'b0;
        if (!enable_timer) begin
            phase_d = '0;
            bit_d   = '0;
        end else begin
            // Any data edge re-aligns to phase 1, as do idle start and the wrap.
            if (d_edge || (phase_q == '0) || (phase_q == PHASE_LAST)) begin
                phase_d = PHASE_ONE;
            end else begin
                phase_d = phase_q + PW'(1);
            end
            if (shift_enable) begin
                if (bit_q == BIT_LAST) begin
                    bit_d  = '0;
                    byte_d = 1'b1;
                end else begin
                    bit_d  = bit_q + BW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            phase_q <= '0;
            bit_q   <= '0;
            byte_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
        end
    end

    assign sample_phase  = phase_q;
    assign bit_count     = bit_q;
    assign byte_received = byte_q;

endmodule

// File: tb/tb_rx_bit_timer.sv
// Self-checking bench for rx_bit_timer: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a cycles-since-alignment model.
module tb_rx_bit_timer;

    localparam int SPB = 8;
    localparam int SP  = 4;
    localparam int BPB = 8;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       enable_timer = 1'b0;
    logic       d_edge = 1'b0;
    logic       stuff_bit = 1'b0;
    logic       shift_enable;
    logic       byte_received;
    logic [2:0] bit_count;
    logic [3:0] sample_phase;

    int checks = 0;
    int failures = 0;

    rx_bit_timer #(
        .SAMPLES_PER_BIT(SPB),
        .SAMPLE_POINT   (SP),
        .BITS_PER_BYTE  (BPB)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .enable_timer (enable_timer),
        .d_edge       (d_edge),
        .stuff_bit    (stuff_bit),
        .shift_enable (shift_enable),
        .byte_received(byte_received),
        .bit_count    (bit_count),
        .sample_phase (sample_phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: phase is simply (cycles since last alignment) mod SPB, plus one.
    bit m_idle  = 1'b1;
    int m_since = 0;
    int m_cnt   = 0;
    bit m_br    = 1'b0;

    function automatic int exp_phase();
        return m_idle ? 0 : (m_since % SPB) + 1;
    endfunction

    function automatic int exp_shift();
        return (!m_idle && enable_timer && !stuff_bit && exp_phase() == SP) ? 1 : 0;
    endfunction

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_idle = 1'b1; m_since = 0; m_cnt = 0; m_br = 1'b0;
        end else if (!enable_timer) begin
            m_idle = 1'b1; m_since = 0; m_cnt = 0; m_br = 1'b0;
        end else begin
            if (exp_shift() == 1) begin
                m_br  = (m_cnt == BPB - 1);
                m_cnt = (m_cnt + 1) % BPB;
            end else begin
                m_br = 1'b0;
            end
            if (d_edge || m_idle) begin
                m_since = 0;
                m_idle  = 1'b0;
            end else begin
                m_since++;
            end
        end
    end

    always @(negedge clk) begin
        chk("mdl_phase", int'(sample_phase), exp_phase());
        chk("mdl_shift", int'(shift_enable), exp_shift());
        chk("mdl_bitcnt", int'(bit_count), m_cnt);
        chk("mdl_byte", int'(byte_received), int'(m_br));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Enable from idle and run one clean byte; cycle c is the period after edge c.
    task automatic run_free_byte();
        enable_timer = 1'b1;
        for (int c = 0; c <= 63; c++) begin
            tick();
            chk("fb_phase", int'(sample_phase), (c % 8) + 1);
            chk("fb_shift", int'(shift_enable), (c >= 3 && c <= 59 && (c - 3) % 8 == 0) ? 1 : 0);
            chk("fb_byte", int'(byte_received), (c == 60) ? 1 : 0);
            if (c == 59) chk("fb_bc59", int'(bit_count), 7);
            if (c == 60) chk("fb_bc60", int'(bit_count), 0);
        end
        enable_timer = 1'b0;
        tick();
    endtask

    initial begin
        // 1: reset with enable high, then idle with enable low
        enable_timer = 1'b1;
        tick(); tick();
        chk("rst_phase", int'(sample_phase), 0);
        chk("rst_shift", int'(shift_enable), 0);
        chk("rst_bc", int'(bit_count), 0);
        chk("rst_byte", int'(byte_received), 0);
        enable_timer = 1'b0;
        n_rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_phase", int'(sample_phase), 0);
            chk("idle_shift", int'(shift_enable), 0);
        end

        // 2: free-running byte
        run_free_byte();

        // 3: re-alignment at phase 6
        enable_timer = 1'b1;
        for (int c = 0; c <= 5; c++) tick();
        chk("ra_phase6", int'(sample_phase), 6);
        d_edge = 1'b1;
        tick();
        d_edge = 1'b0;
        chk("ra_phase1", int'(sample_phase), 1);
        tick(); chk("ra_noshift1", int'(shift_enable), 0);
        tick(); chk("ra_noshift2", int'(shift_enable), 0);
        tick(); chk("ra_shift", int'(shift_enable), 1);
        chk("ra_phase4", int'(sample_phase), 4);
        enable_timer = 1'b0;
        tick();

        // 4: stuffed bit at the third sample point
        enable_timer = 1'b1;
        for (int c = 0; c <= 70; c++) begin
            tick();
            stuff_bit = (c == 19);
            #1;
            chk("st_shift", int'(shift_enable),
                (c >= 3 && c <= 67 && (c - 3) % 8 == 0 && c != 19) ? 1 : 0);
            chk("st_byte", int'(byte_received), (c == 68) ? 1 : 0);
            if (c == 20) chk("st_bc20", int'(bit_count), 2);
        end
        stuff_bit = 1'b0;
        enable_timer = 1'b0;
        tick();

        // 5: abort mid-byte, then restart cleanly
        enable_timer = 1'b1;
        for (int c = 0; c <= 36; c++) tick();
        chk("ab_bc5", int'(bit_count), 5);
        enable_timer = 1'b0;
        tick();
        chk("ab_phase", int'(sample_phase), 0);
        chk("ab_bc", int'(bit_count), 0);
        for (int i = 0; i < 30; i++) begin
            tick();
            chk("ab_nobyte", int'(byte_received), 0);
        end
        run_free_byte();

        // 6: d_edge at the sample point, then async reset mid-byte
        enable_timer = 1'b1;
        for (int c = 0; c <= 3; c++) tick();
        d_edge = 1'b1;
        #1;
        chk("se_shift", int'(shift_enable), 1);
        tick();
        d_edge = 1'b0;
        chk("se_phase1", int'(sample_phase), 1);
        chk("se_bc1", int'(bit_count), 1);
        tick(); tick(); tick();
        chk("se_shift2", int'(shift_enable), 1);
        for (int i = 0; i < 10; i++) tick();
        n_rst = 1'b0;
        #1;
        chk("ar_phase", int'(sample_phase), 0);
        chk("ar_bc", int'(bit_count), 0);
        chk("ar_shift", int'(shift_enable), 0);
        chk("ar_byte", int'(byte_received), 0);
        enable_timer = 1'b0;
        tick();
        n_rst = 1'b1;
        tick();

        // Randomized traffic, checked by the per-cycle model process
        for (int i = 0; i < 4000; i++) begin
            tick();
            enable_timer = ($urandom_range(0, 99) < 97);
            d_edge       = (i % 1000 < 500) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 49) == 0);
            stuff_bit    = ($urandom_range(0, 5) == 0);
            n_rst        = ($urandom_range(0, 999) != 0);
        end
        n_rst = 1'b1;
        enable_timer = 1'b0;
        d_edge = 1'b0;
        stuff_bit = 1'b0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
